// File: rtl/decoder_2x4_strobe.sv
// Handshaked 2**N_SEL-way decoder: each accepted code drives one line of y for
// HOLD_CYCLES clocks, then a GAP_CYCLES recovery window with done/aborted strobes.
module decoder_2x4_strobe #(
  parameter int N_SEL       = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_SEL-1:0]      i,
  input  logic                  i_valid,
  output logic                  in_ready,
  output logic [2**N_SEL-1:0]   y,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int N_OUT   = 2**N_SEL;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_OUT-1:0] y_nxt;
  logic             busy_nxt, done_nxt, aborted_nxt;

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous, so rst_n is tested inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      y       <= y_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      aborted <= aborted_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    y_nxt       = y;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid && in_ready) begin
          y_nxt     = N_OUT'(1) << i;
          cnt_nxt   = HOLD_LAST;
          state_nxt = HOLD;
          busy_nxt  = 1'b1;
        end
      end
      HOLD: begin
        // Dropping en wins over a normal completion on the last HOLD cycle.
        if (!en) begin
          y_nxt       = '0;
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          y_nxt    = '0;
          done_nxt = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LAST;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      GAP: begin
        if (!en) begin
          state_nxt   = IDLE;
          busy_nxt    = 1'b0;
          aborted_nxt = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        y_nxt     = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && en && rst_n;
  end

endmodule
